// File: rtl/spi_reg_arbiter.sv
// spi_reg_arbiter: NREG x 8-bit register bank shared between an SPI slave
// (write strobe plus readback) and a host with a req/ack handshake. SPI
// writes go into a one-entry pending buffer because the SPI side cannot be
// stalled. A round-robin IDLE/GNT_SPI/GNT_HOST FSM commits one access per
// grant.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   spi_wr/addr/wdata    SPI write strobe, address, data
//   spi_rdata            registered readback of reg[spi_addr]
//   host_req/we/addr/wdata  host request (level), direction, address, data
//   host_ack, host_rdata one-cycle completion pulse; read data held between acks
//   cfg_out              flattened register bank, reg i at [8i+7:8i]
//   spi_ovf              sticky flag set when an SPI write was lost
//
// Optional feature: define SPI_ARB_LOCK_EN to make reg NREG-1 bit 0 a host
// write lock for registers 0..NREG-2.
module spi_reg_arbiter #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        spi_wr,
  input  logic [7:0]                  spi_addr,
  input  logic [7:0]                  spi_wdata,
  output logic [7:0]                  spi_rdata,
  input  logic                        host_req,
  input  logic                        host_we,
  input  logic [7:0]                  host_addr,
  input  logic [7:0]                  host_wdata,
  output logic                        host_ack,
  output logic [7:0]                  host_rdata,
  output logic [8*(1<<ADDR_W)-1:0]    cfg_out,
  output logic                        spi_ovf
);

  localparam int unsigned NREG = 32'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, GNT_SPI, GNT_HOST} state_e;

  state_e             state_q, state_d;
  logic               rr_host_q, rr_host_d;   // 1: host wins the next tie
  logic               pend_q, pend_d;
  logic [7:0]         pend_addr_q, pend_addr_d;
  logic [7:0]         pend_data_q, pend_data_d;
  logic               spi_ovf_q, spi_ovf_d;
  logic               host_ack_q, host_ack_d;
  logic [7:0]         host_rdata_q, host_rdata_d;
  logic [7:0]         spi_rdata_q, spi_rdata_d;
  logic [7:0]         regs_q [NREG];

  logic               wr_en_c;
  logic [ADDR_W-1:0]  wr_idx_c;
  logic [7:0]         wr_data_c;
  logic               spi_pend_c;
  logic               lock_blk_c;

  function automatic logic in_range(input logic [7:0] a);
    return 32'(a) < NREG;
  endfunction

  // A strobe arriving this cycle counts as pending so a same-cycle tie
  // with the host is resolved by the round-robin pointer.
  assign spi_pend_c = pend_q | spi_wr;

`ifdef SPI_ARB_LOCK_EN
  // Lock blocks host writes to every register except the lock register.
  assign lock_blk_c = regs_q[NREG-1][0] &&
                      (host_addr[ADDR_W-1:0] != ADDR_W'(NREG-1));
`else
  assign lock_blk_c = 1'b0;
`endif

  // Next-state, commit and output logic.
  always_comb begin
    state_d      = state_q;
    rr_host_d    = rr_host_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    spi_ovf_d    = spi_ovf_q;
    host_ack_d   = 1'b0;
    host_rdata_d = host_rdata_q;
    wr_en_c      = 1'b0;
    wr_idx_c     = '0;
    wr_data_c    = '0;
    spi_rdata_d  = in_range(spi_addr) ? regs_q[spi_addr[ADDR_W-1:0]] : 8'h00;

    case (state_q)
      IDLE: begin
        if (spi_pend_c && (!host_req || !rr_host_q)) begin
          state_d   = GNT_SPI;
          rr_host_d = 1'b1;
        end else if (host_req) begin
          state_d   = GNT_HOST;
          rr_host_d = 1'b0;
        end
      end
      GNT_SPI: begin
        state_d   = IDLE;
        pend_d    = 1'b0;
        wr_en_c   = in_range(pend_addr_q);
        wr_idx_c  = pend_addr_q[ADDR_W-1:0];
        wr_data_c = pend_data_q;
      end
      GNT_HOST: begin
        state_d    = IDLE;
        host_ack_d = 1'b1;
        if (host_we) begin
          wr_en_c   = in_range(host_addr) && !lock_blk_c;
          wr_idx_c  = host_addr[ADDR_W-1:0];
          wr_data_c = host_wdata;
        end else begin
          host_rdata_d = in_range(host_addr) ? regs_q[host_addr[ADDR_W-1:0]] : 8'h00;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture after the drain clear so a write in the draining cycle is kept.
    if (spi_wr) begin
      if (pend_q && (state_q != GNT_SPI)) begin
        spi_ovf_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_addr_d = spi_addr;
        pend_data_d = spi_wdata;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_host_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      spi_ovf_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rdata_q <= '0;
      spi_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      rr_host_q    <= rr_host_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      spi_ovf_q    <= spi_ovf_d;
      host_ack_q   <= host_ack_d;
      host_rdata_q <= host_rdata_d;
      spi_rdata_q  <= spi_rdata_d;
    end
  end

  // Register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      regs_q[wr_idx_c] <= wr_data_c;
    end
  end

  for (genvar g = 0; g < int'(NREG); g++) begin : g_cfg
    assign cfg_out[8*g +: 8] = regs_q[g];
  end

  assign spi_rdata  = spi_rdata_q;
  assign host_ack   = host_ack_q;
  assign host_rdata = host_rdata_q;
  assign spi_ovf    = spi_ovf_q;

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter: transaction-level register model,
// host read data scoreboard checked by an independent ack monitor.
module tb_spi_reg_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREG   = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                spi_wr = 1'b0;
  logic [7:0]          spi_addr = '0;
  logic [7:0]          spi_wdata = '0;
  logic [7:0]          spi_rdata;
  logic                host_req = 1'b0;
  logic                host_we = 1'b0;
  logic [7:0]          host_addr = '0;
  logic [7:0]          host_wdata = '0;
  logic                host_ack;
  logic [7:0]          host_rdata;
  logic [8*NREG-1:0]   cfg_out;
  logic                spi_ovf;

  spi_reg_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_rdata(spi_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .cfg_out(cfg_out), .spi_ovf(spi_ovf)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mreg [NREG];
  bit         fav_host = 1'b0;
  logic [7:0] last_rd = '0;
  bit         exp_ovf = 1'b0;
  logic [7:0] exp_q [$];
  bit         prev_ack = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit inr(input logic [7:0] a);
    return 32'(a) < NREG;
  endfunction

  function automatic logic [8*NREG-1:0] exp_cfg();
    logic [8*NREG-1:0] v;
    for (int i = 0; i < int'(NREG); i++) v[8*i +: 8] = mreg[i];
    return v;
  endfunction

  function automatic bit locked_for(input logic [7:0] a);
`ifdef SPI_ARB_LOCK_EN
    return mreg[NREG-1][0] && (32'(a) != NREG - 1);
`else
    return 1'b0 && (a == 8'h00);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NREG); i++) mreg[i] = 8'h00;
    fav_host = 1'b0;
    last_rd  = 8'h00;
    exp_ovf  = 1'b0;
  endtask

  task automatic model_spi(input logic [7:0] a, input logic [7:0] d);
    if (inr(a)) mreg[a[3:0]] = d;
    fav_host = 1'b1;
  endtask

  // Host access in model order; queues what host_rdata must show at the ack.
  task automatic model_host(input bit we, input logic [7:0] a, input logic [7:0] d);
    if (we) begin
      if (inr(a) && !locked_for(a)) mreg[a[3:0]] = d;
    end else begin
      last_rd = inr(a) ? mreg[a[3:0]] : 8'h00;
    end
    exp_q.push_back(last_rd);
    fav_host = 1'b0;
  endtask

  // Ack monitor: pops the scoreboard on every ack and checks pulse width.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack = 1'b0;
    end else begin
      if (host_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL host_ack_unexpected actual=1 required=0");
        end else begin
          chk("host_rdata", 128'(host_rdata), 128'(exp_q.pop_front()));
        end
        chk("host_ack_width", 128'(prev_ack), 128'(0));
      end
      prev_ack = host_ack;
    end
  end

  task automatic wait_ack(input int start_n, input bit chk_lat);
    int n = start_n;
    bit got = host_ack;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      got = host_ack;
    end
    host_req = 1'b0;
    chk("host_ack_seen", 128'(got), 128'(1));
    if (chk_lat) chk("host_latency", 128'(n), 128'(2));
  endtask

  task automatic host_access(input bit we, input logic [7:0] a, input logic [7:0] d, input bit chk_lat);
    @(negedge clk);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    model_host(we, a, d);
    wait_ack(0, chk_lat);
  endtask

  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    spi_wr = 1'b1; spi_addr = a; spi_wdata = d;
    model_spi(a, d);
    @(negedge clk);
    spi_wr = 1'b0;
  endtask

  // SPI strobe and host request in the same cycle; the model applies the
  // round-robin winner first.
  task automatic contention(input logic [7:0] sa, input logic [7:0] sd,
                            input bit hwe, input logic [7:0] ha, input logic [7:0] hd);
    @(negedge clk);
    spi_wr = 1'b1; spi_addr = sa; spi_wdata = sd;
    host_req = 1'b1; host_we = hwe; host_addr = ha; host_wdata = hd;
    if (fav_host) begin
      model_host(hwe, ha, hd);
      model_spi(sa, sd);
    end else begin
      model_spi(sa, sd);
      model_host(hwe, ha, hd);
    end
    @(negedge clk);
    spi_wr = 1'b0;
    wait_ack(1, 1'b0);
  endtask

  task automatic check_state();
    logic [7:0] sa;
    repeat (5) @(negedge clk);
    chk("cfg_out", 128'(cfg_out), 128'(exp_cfg()));
    sa = 8'($urandom_range(0, 23));
    spi_addr = sa;
    @(negedge clk);
    chk("spi_rdata", 128'(spi_rdata), 128'(inr(sa) ? mreg[sa[3:0]] : 8'h00));
    chk("spi_ovf", 128'(spi_ovf), 128'(exp_ovf));
  endtask

  task automatic check_reset_outputs();
    chk("rst_cfg_out", 128'(cfg_out), 128'(0));
    chk("rst_spi_rdata", 128'(spi_rdata), 128'(0));
    chk("rst_host_rdata", 128'(host_rdata), 128'(0));
    chk("rst_host_ack", 128'(host_ack), 128'(0));
    chk("rst_spi_ovf", 128'(spi_ovf), 128'(0));
  endtask

  initial begin
    logic [7:0] a, d, a2, d2;
    int op;

    // Reset state.
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;

    // Single SPI write, then readback and host read.
    spi_write(8'h03, 8'hA5);
    repeat (2) @(negedge clk);
    chk("spi_write_cfg", 128'(cfg_out[31:24]), 128'(8'hA5));
    check_state();
    host_access(1'b0, 8'h03, 8'h00, 1'b1);
    check_state();

    // Tie after a host grant: SPI first, then host; host value wins.
    contention(8'h01, 8'h11, 1'b1, 8'h01, 8'h22);
    check_state();
    chk("contention_reg1", 128'(cfg_out[15:8]), 128'(8'h22));

    // Out-of-range host write and read.
    host_access(1'b1, 8'h20, 8'h77, 1'b1);
    check_state();
    host_access(1'b0, 8'h20, 8'h00, 1'b1);
    check_state();
    chk("oor_read", 128'(host_rdata), 128'(0));

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 19));
      d  = 8'($urandom);
      a2 = 8'($urandom_range(0, 19));
      d2 = 8'($urandom);
      case (op)
        0: spi_write(a, d);
        1: host_access(1'b1, a, d, 1'b1);
        2: host_access(1'b0, a, 8'h00, 1'b1);
        default: contention(a, d, 1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? a : a2, d2);
      endcase
      check_state();
    end

    // Lock behaviour (ordinary register when the lock feature is absent).
    host_access(1'b1, 8'h0F, 8'h01, 1'b1);
    d = mreg[2];
    host_access(1'b1, 8'h02, 8'h55, 1'b1);
    check_state();
`ifdef SPI_ARB_LOCK_EN
    chk("lock_blocks_host", 128'(cfg_out[23:16]), 128'(d));
`else
    chk("nolock_host_write", 128'(cfg_out[23:16]), 128'(8'h55));
`endif
    spi_write(8'h02, 8'h5A);
    check_state();
    chk("lock_spi_write", 128'(cfg_out[23:16]), 128'(8'h5A));
    host_access(1'b1, 8'h0F, 8'h00, 1'b1);
    check_state();

    // Overflow: two strobes on consecutive cycles around a host grant.
    a = 8'($urandom_range(0, 15));
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h03;
    model_host(1'b0, 8'h03, 8'h00);
    @(negedge clk);
    spi_wr = 1'b1; spi_addr = a; spi_wdata = 8'hC3;
    model_spi(a, 8'hC3);
    @(negedge clk);
    chk("ovf_host_ack", 128'(host_ack), 128'(1));
    host_req = 1'b0;
    spi_wdata = 8'h3C;
    @(negedge clk);
    spi_wr = 1'b0;
    exp_ovf = 1'b1;
    check_state();
    chk("ovf_first_kept", 128'(cfg_out[8*a[3:0] +: 8]), 128'(8'hC3));

    // Reset during a host grant: no write, no ack, everything cleared.
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 8'h99;
    @(negedge clk);
    rst = 1'b1;
    host_req = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    check_state();

    // Pointer back to SPI after reset: tie resolves SPI first.
    contention(8'h04, 8'h44, 1'b1, 8'h04, 8'h66);
    check_state();
    chk("post_rst_tie", 128'(cfg_out[39:32]), 128'(8'h66));

    repeat (3) @(negedge clk);
    chk("scoreboard_drain", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_arbiter.md
SPI_REG_ARBITER -- requirements
Module: spi_reg_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_W, 4, register index width; the bank holds NREG = 2^ADDR_W 8-bit registers.
REQ-002 SHALL have ports, one per line:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_wr  in  1  one-cycle write strobe from the SPI slave.
- spi_addr  in  8  SPI register address; it also selects the SPI readback.
- spi_wdata  in  8  SPI write data.
- spi_rdata  out  8  readback to the SPI slave's tx_data.
- host_req  in  1  host access request, level.
- host_we  in  1  host write (1) or read (0); valid while host_req is high.
- host_addr  in  8  host register address.
- host_wdata  in  8  host write data.
- host_ack  out  1  one-cycle access-complete pulse.
- host_rdata  out  8  host read data; valid when host_ack is high.
- cfg_out  out  8*NREG  flattened register bank; register i is at bits [8i+7:8i].
- spi_ovf  out  1  sticky flag: an SPI write was lost.
REQ-003 SHALL be a single clock domain (clk); reset is asynchronous and active-high (rst).

Function
REQ-004 SHALL capture each spi_wr into a one-entry pending buffer (address and data), because the SPI side cannot be stalled.
REQ-005 SHALL set spi_ovf if spi_wr arrives while the buffer is full and not being drained that cycle; the new write is dropped and the old one is kept.
REQ-006 SHALL treat spi_wr arriving in the same cycle the buffer drains as accepted, with no overflow.
REQ-007 SHALL use an FSM with states IDLE, GNT_SPI and GNT_HOST; each GNT state lasts exactly 1 cycle and then returns to IDLE.
REQ-008 SHALL, in IDLE, go to GNT_SPI if only the SPI buffer is pending, and to GNT_HOST if only host_req is high.
REQ-009 SHALL, when both are pending in IDLE, grant the requester not granted last (round-robin); the pointer initialises to favour SPI.
REQ-010 SHALL, in GNT_SPI, write the buffered data to the register and clear the buffer.
REQ-011 SHALL, in GNT_HOST, write host_wdata when host_we=1, or load host_rdata with the register contents when host_we=0.
REQ-012 SHALL pulse host_ack for exactly 1 cycle in GNT_HOST; latency from host_req rising in IDLE with no contention is 2 clk edges.
REQ-013 SHALL treat host_req still high in the IDLE following an ack as a new request; the host drops req on ack to avoid a repeat.
REQ-014 SHALL ignore writes to addresses >= NREG, and return 0x00 for reads of such addresses; ack is still given.
REQ-015 SHALL register spi_rdata every cycle as reg[spi_addr] (1-cycle latency, 0x00 if out of range); a write committed at edge N is visible at edge N+1.
REQ-016 SHALL drive cfg_out directly from the register bank.
REQ-017 SHALL hold host_rdata between acks.

Reset
REQ-018 SHALL, while rst is high, force: all registers, spi_rdata, host_rdata and spi_ovf to 0; host_ack to 0; FSM to IDLE; pending buffer empty; round-robin pointer to SPI.
REQ-019 SHALL abandon an in-flight grant on reset: no write occurs and no ack is issued.

Configuration
REQ-020 SHALL support macro SPI_ARB_LOCK_EN.
- Defined: register NREG-1 bit 0 is a lock; when it is set, host writes to registers 0..NREG-2 are dropped (ack still given) and host writes to register NREG-1 proceed; SPI writes are never blocked.
- Undefined: register NREG-1 is an ordinary register.

Verification
REQ-021 SPI write: spi_wr with addr 0x03, data 0xA5 -> cfg_out[31:24]=0xA5 within 3 cycles; spi_addr=0x03 gives spi_rdata=0xA5 one cycle later.
REQ-022 Host read: host_req with we=0, addr 0x03 after REQ-021 -> host_ack pulses once, host_rdata=0xA5, 2 cycles after req.
REQ-023 Contention: spi_wr (0x01, 0x11) and host write (0x01, 0x22) in the same cycle with the pointer favouring SPI -> SPI commits first, then host; final reg1=0x22.
REQ-024 Overflow: two spi_wr 1 cycle apart while the host holds the grant -> spi_ovf=1, first write kept; after rst, spi_ovf=0.
REQ-025 Out of range: host write to 0x20 -> ack given, cfg_out unchanged; read of 0x20 -> host_rdata 0x00.
REQ-026 Lock (SPI_ARB_LOCK_EN defined): host writes 0x01 to reg 15, then 0x55 to reg 2 -> reg2 unchanged; an SPI write of 0x55 to reg 2 succeeds.
